// File: rtl/csr_unit_if.sv
// CSR request/response bundle between the pipeline (master) and the CSR sequencer (slave).
interface csr_unit_if #(
    parameter int XLEN = 32
);
    logic            csr_req_i;
    logic [11:0]     csr_addr_i;
    logic [1:0]      csr_control_i;
    logic            csr_src_i;
    logic [4:0]      rs1_idx_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_done_o;
    logic            csr_busy_o;
    logic            csr_illegal_o;

    modport master (
        output csr_req_i, csr_addr_i, csr_control_i, csr_src_i, rs1_idx_i, rs1_data_i,
        input  csr_rdata_o, csr_done_o, csr_busy_o, csr_illegal_o
    );

    modport slave (
        input  csr_req_i, csr_addr_i, csr_control_i, csr_src_i, rs1_idx_i, rs1_data_i,
        output csr_rdata_o, csr_done_o, csr_busy_o, csr_illegal_o
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR storage (mscratch, mcycle, minstret) with a two-cycle read-modify-write
// sequencer.
//  state | meaning
//  IDLE  | waiting for a CSR request; accepting one latches the old value and asserts busy
//  RMW   | commits the write at the end of this cycle; done/illegal/rdata presented
module csr_unit #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] MSCRATCH_RST = 32'h0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    csr_unit_if.slave  bus,
    input  logic       instr_retire_i
);
    localparam logic [1:0] CSR_NA    = 2'b00;
    localparam logic [1:0] CSR_PASS  = 2'b01;
    localparam logic [1:0] CSR_SET   = 2'b10;
    localparam logic [1:0] CSR_CLEAR = 2'b11;
    localparam logic       CSR_SRC_IMM = 1'b1;

    typedef enum logic {IDLE, RMW} state_t;

    state_t          state_q, state_d;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] old_q, operand_q, rdata_q, mscratch_q;
    logic [1:0]      ctrl_q;
    logic            we_q, illegal_q;
    logic [63:0]     mcycle_q, minstret_q;

    logic [XLEN-1:0] rd_val, operand, new_val;
    logic            mapped, is_alias, suppress, illegal_d, accept, commit;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (bus.csr_req_i) begin
                accept  = 1'b1;
                state_d = RMW;
            end
            RMW: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val   = '0;
        mapped   = 1'b1;
        is_alias = 1'b0;
        case (bus.csr_addr_i)
            12'h340: rd_val = mscratch_q;
            12'hB00: rd_val = XLEN'(mcycle_q[31:0]);
            12'hB80: rd_val = XLEN'(mcycle_q[63:32]);
            12'hB02: rd_val = XLEN'(minstret_q[31:0]);
            12'hB82: rd_val = XLEN'(minstret_q[63:32]);
            12'hC00: begin rd_val = XLEN'(mcycle_q[31:0]);    is_alias = 1'b1; end
            12'hC80: begin rd_val = XLEN'(mcycle_q[63:32]);   is_alias = 1'b1; end
            12'hC02: begin rd_val = XLEN'(minstret_q[31:0]);  is_alias = 1'b1; end
            12'hC82: begin rd_val = XLEN'(minstret_q[63:32]); is_alias = 1'b1; end
            default: mapped = 1'b0;
        endcase
    end

    // SET/CLEAR with the x0/zero-uimm field is a pure read, whichever source is selected.
    always_comb begin
        operand   = (bus.csr_src_i == CSR_SRC_IMM) ? {{(XLEN-5){1'b0}}, bus.rs1_idx_i}
                                                   : bus.rs1_data_i;
        suppress  = ((bus.csr_control_i == CSR_SET) || (bus.csr_control_i == CSR_CLEAR))
                    && (bus.rs1_idx_i == 5'd0);
        illegal_d = !mapped || (bus.csr_control_i == CSR_NA) || (is_alias && !suppress);
    end

    always_comb begin
        case (ctrl_q)
            CSR_SET:   new_val = old_q | operand_q;
            CSR_CLEAR: new_val = old_q & ~operand_q;
            default:   new_val = operand_q;
        endcase
        commit = (state_q == RMW) && we_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            old_q     <= '0;
            operand_q <= '0;
            ctrl_q    <= CSR_NA;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q    <= bus.csr_addr_i;
                old_q     <= rd_val;
                operand_q <= operand;
                ctrl_q    <= bus.csr_control_i;
                we_q      <= !illegal_d && !suppress;
                illegal_q <= illegal_d;
                rdata_q   <= illegal_d ? '0 : rd_val;
            end else begin
                rdata_q <= '0;
            end
        end
    end

    // A committed write to one counter half replaces the increment for that cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mscratch_q <= XLEN'(MSCRATCH_RST);
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (commit && addr_q == 12'h340) mscratch_q <= new_val;

            if (commit && addr_q == 12'hB00)      mcycle_q[31:0]  <= new_val[31:0];
            else if (commit && addr_q == 12'hB80) mcycle_q[63:32] <= new_val[31:0];
            else                                  mcycle_q        <= mcycle_q + 64'd1;

            if (commit && addr_q == 12'hB02)      minstret_q[31:0]  <= new_val[31:0];
            else if (commit && addr_q == 12'hB82) minstret_q[63:32] <= new_val[31:0];
            else if (instr_retire_i)              minstret_q        <= minstret_q + 64'd1;
        end
    end

    assign bus.csr_busy_o    = accept;
    assign bus.csr_done_o    = (state_q == RMW);
    assign bus.csr_illegal_o = (state_q == RMW) && illegal_q;
    assign bus.csr_rdata_o   = rdata_q;
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: stimulus pushes expected responses, a negedge monitor pops
// and compares them on every csr_done_o pulse.
module tb_csr_unit;
    localparam logic [1:0] CSR_NA    = 2'b00;
    localparam logic [1:0] CSR_PASS  = 2'b01;
    localparam logic [1:0] CSR_SET   = 2'b10;
    localparam logic [1:0] CSR_CLEAR = 2'b11;
    localparam logic       REG = 1'b0;
    localparam logic       IMM = 1'b1;
    localparam logic [31:0] RST_VAL = 32'h1234_5678;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        bit          chk_data;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic retire = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    csr_unit_if #(.XLEN(32)) bus_if ();

    csr_unit #(.XLEN(32), .MSCRATCH_RST(RST_VAL)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .bus            (bus_if.slave),
        .instr_retire_i (retire)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus_if.csr_done_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_illegal"}, 32'(bus_if.csr_illegal_o), 32'(e.ill));
                if (e.chk_data) check({e.name, "_rdata"}, bus_if.csr_rdata_o, e.data);
            end
        end else if (rst_n === 1'b1) begin
            check("rdata_zero_when_idle", bus_if.csr_rdata_o, 32'h0);
        end
    end

    task automatic csr_op(input string name, input logic [11:0] addr, input logic [1:0] ctl,
                          input logic src, input logic [4:0] idx, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_ill, input bit chk_data);
        exp_t e;
        e.data = exp_data; e.ill = exp_ill; e.chk_data = chk_data; e.name = name;
        sb.push_back(e);
        bus_if.csr_req_i     = 1'b1;
        bus_if.csr_addr_i    = addr;
        bus_if.csr_control_i = ctl;
        bus_if.csr_src_i     = src;
        bus_if.rs1_idx_i     = idx;
        bus_if.rs1_data_i    = data;
        #1;
        check({name, "_busy_n"}, 32'(bus_if.csr_busy_o), 32'h1);
        @(posedge clk); #1;
        check({name, "_busy_n1"}, 32'(bus_if.csr_busy_o), 32'h0);
        @(posedge clk); #1;
        bus_if.csr_req_i = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp_data);
        csr_op(name, addr, CSR_SET, REG, 5'd0, 32'hFFFF_FFFF, exp_data, 1'b0, 1'b1);
    endtask

    initial begin
        bus_if.csr_req_i     = 1'b0;
        bus_if.csr_addr_i    = '0;
        bus_if.csr_control_i = CSR_NA;
        bus_if.csr_src_i     = REG;
        bus_if.rs1_idx_i     = '0;
        bus_if.rs1_data_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus_if.csr_busy_o), 32'h0);
        check("rst_done", 32'(bus_if.csr_done_o), 32'h0);
        check("rst_illegal", 32'(bus_if.csr_illegal_o), 32'h0);
        check("rst_rdata", bus_if.csr_rdata_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd("rst_mscratch", 12'h340, RST_VAL);
        csr_op("pass", 12'h340, CSR_PASS, REG, 5'd1, 32'hA5A5_0000, RST_VAL, 1'b0, 1'b1);
        csr_op("set_imm", 12'h340, CSR_SET, IMM, 5'h0F, 32'hFFFF_FFFF, 32'hA5A5_0000, 1'b0, 1'b1);
        csr_op("clear_reg", 12'h340, CSR_CLEAR, REG, 5'd2, 32'hA500_0000, 32'hA5A5_000F, 1'b0, 1'b1);
        rd("final_mscratch", 12'h340, 32'h00A5_000F);

        csr_op("fill", 12'h340, CSR_PASS, REG, 5'd3, 32'hFFFF_FFFF, 32'h00A5_000F, 1'b0, 1'b1);
        csr_op("clear_x0", 12'h340, CSR_CLEAR, REG, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        rd("after_suppress", 12'h340, 32'hFFFF_FFFF);

        retire = 1'b1;
        repeat (10) @(posedge clk);
        #1 retire = 1'b0;
        rd("instret", 12'hC02, 32'd10);
        rd("instreth", 12'hC82, 32'd0);

        csr_op("wr_mcycleh", 12'hB80, CSR_PASS, REG, 5'd4, 32'h0, 32'h0, 1'b0, 1'b1);
        csr_op("wr_mcycle", 12'hB00, CSR_PASS, REG, 5'd5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rd("mcycleh_carry", 12'hB80, 32'd1);

        csr_op("ill_c00", 12'hC00, CSR_PASS, REG, 5'd6, 32'h0, 32'h0, 1'b1, 1'b1);
        csr_op("ill_c80", 12'hC80, CSR_PASS, REG, 5'd6, 32'h55, 32'h0, 1'b1, 1'b1);
        rd("cycleh_unchanged", 12'hC80, 32'd1);
        csr_op("ill_c82_set", 12'hC82, CSR_SET, IMM, 5'h1F, 32'h0, 32'h0, 1'b1, 1'b1);
        rd("instreth_unchanged", 12'hC82, 32'd0);
        csr_op("ill_unmapped", 12'h123, CSR_SET, REG, 5'd3, 32'hFF, 32'h0, 1'b1, 1'b1);
        csr_op("ill_na", 12'h340, CSR_NA, REG, 5'd3, 32'h0, 32'h0, 1'b1, 1'b1);
        rd("mscratch_after_na", 12'h340, 32'hFFFF_FFFF);

        // Abort a write by resetting during its RMW cycle.
        bus_if.csr_req_i     = 1'b1;
        bus_if.csr_addr_i    = 12'h340;
        bus_if.csr_control_i = CSR_PASS;
        bus_if.csr_src_i     = REG;
        bus_if.rs1_idx_i     = 5'd7;
        bus_if.rs1_data_i    = 32'h0BAD_F00D;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus_if.csr_req_i = 1'b0;
        #1;
        check("abort_done", 32'(bus_if.csr_done_o), 32'h0);
        check("abort_rdata", bus_if.csr_rdata_o, 32'h0);
        @(posedge clk); #1;
        check("abort_busy", 32'(bus_if.csr_busy_o), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd("abort_mscratch", 12'h340, RST_VAL);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
